// File: rtl/mul_batch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_batch_sequencer
//  Description : Unpacks a 512-bit line of operand pairs, issues one pair per
//                cycle into a pipelined multiplier, tracks in-flight products
//                with a tag shift register and returns the packed products as
//                one 512-bit line over a valid/ready handshake.
//                Optional macro MUL_SEQ_CHECKSUM_EN places the XOR of all
//                returned products in out_line[511:480].
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_batch_sequencer #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2,
    parameter int NUM_PAIRS      = 8,
    parameter int CNT_W          = $clog2(NUM_PAIRS + 1)
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                in_valid,
    output logic                     in_ready,
    input  wire logic [511:0]        in_line,
    input  wire logic [CNT_W-1:0]    in_count,
    output logic [DATA_LEN-1:0]      mul_a,
    output logic [DATA_LEN-1:0]      mul_b,
    input  wire logic [DATA_LEN-1:0] mul_result,
    output logic                     out_valid,
    input  wire logic                out_ready,
    output logic [511:0]             out_line,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_overflow,
    output logic                     busy
);

    localparam int         c_IDX_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int         c_OP_W   = 2 * NUM_PAIRS * DATA_LEN;
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_DRAIN  = 2'd2;
    localparam logic [1:0] c_OUTPUT = 2'd3;

    generate
        if (c_OP_W > 512) begin : g_fit_check
            $error("mul_batch_sequencer: 2*NUM_PAIRS*DATA_LEN exceeds 512");
        end
        if (PIPELINE_STAGE < 1) begin : g_stage_check
            $error("mul_batch_sequencer: PIPELINE_STAGE must be >= 1");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_OP_W-1:0]   r_line;
    logic [CNT_W-1:0]    r_n;
    logic                r_overflow;
    logic [DATA_LEN-1:0] r_result [NUM_PAIRS];
    logic [c_IDX_W-1:0]  r_issue_idx;
    logic                r_tag_valid [PIPELINE_STAGE];
    logic [c_IDX_W-1:0]  r_tag_idx   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] w_op_a [NUM_PAIRS];
    logic [DATA_LEN-1:0] w_op_b [NUM_PAIRS];
    logic                w_accept;
    logic                w_issue;
    logic [CNT_W-1:0]    w_count_clamped;
    logic [CNT_W-1:0]    w_n_minus1;
    logic [c_IDX_W-1:0]  w_last_idx;
    logic                w_tag_out_valid;
    logic [c_IDX_W-1:0]  w_tag_out_idx;

    // Split the captured line into per-pair operand views
    generate
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_unpack
            assign w_op_a[gi] = r_line[(2*gi)*DATA_LEN   +: DATA_LEN];
            assign w_op_b[gi] = r_line[(2*gi+1)*DATA_LEN +: DATA_LEN];
        end
        if (c_OP_W < 512) begin : g_unused_upper
            logic w_unused_upper;
            assign w_unused_upper = ^in_line[511:c_OP_W];
        end
    endgenerate

    assign w_count_clamped = (in_count > CNT_W'(NUM_PAIRS)) ? CNT_W'(NUM_PAIRS) : in_count;
    assign w_n_minus1      = r_n - CNT_W'(1);
    assign w_last_idx      = w_n_minus1[c_IDX_W-1:0];
    assign w_tag_out_valid = r_tag_valid[PIPELINE_STAGE-1];
    assign w_tag_out_idx   = r_tag_idx[PIPELINE_STAGE-1];
    assign w_accept        = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        w_issue     = 1'b0;
        case (r_state)
            c_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    w_state_nxt = (w_count_clamped == '0) ? c_OUTPUT : c_ISSUE;
            end
            c_ISSUE: begin
                w_issue = 1'b1;
                if (r_issue_idx == w_last_idx) w_state_nxt = c_DRAIN;
            end
            c_DRAIN: begin
                if (w_tag_out_valid && (w_tag_out_idx == w_last_idx)) w_state_nxt = c_OUTPUT;
            end
            c_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Operands are only presented while issuing; zero otherwise
    assign mul_a = w_issue ? w_op_a[r_issue_idx] : '0;
    assign mul_b = w_issue ? w_op_b[r_issue_idx] : '0;

    // Capture the accepted line, its clamped pair count and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line     <= '0;
            r_n        <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_line     <= in_line[c_OP_W-1:0];
            r_n        <= w_count_clamped;
            r_overflow <= (in_count > CNT_W'(NUM_PAIRS));
        end
    end

    // Issue pointer walks pairs 0..N-1
    always_ff @(posedge clk) begin
        if (reset || w_accept) r_issue_idx <= '0;
        else if (w_issue)      r_issue_idx <= r_issue_idx + c_IDX_W'(1);
    end

    // Tag shift register mirrors the multiplier latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPELINE_STAGE; i++) begin
                r_tag_valid[i] <= 1'b0;
                r_tag_idx[i]   <= '0;
            end
        end else begin
            r_tag_valid[0] <= w_issue;
            r_tag_idx[0]   <= w_issue ? r_issue_idx : '0;
            for (int i = 1; i < PIPELINE_STAGE; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_idx[i]   <= r_tag_idx[i-1];
            end
        end
    end

    // Store each product at the slot named by its emerging tag
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            for (int i = 0; i < NUM_PAIRS; i++) r_result[i] <= '0;
        end else if (w_tag_out_valid) begin
            r_result[w_tag_out_idx] <= mul_result;
        end
    end

    // Pack results; unfilled slots are already zero
    always_comb begin
        out_line = '0;
        for (int i = 0; i < NUM_PAIRS; i++) out_line[i*DATA_LEN +: DATA_LEN] = r_result[i];
`ifdef MUL_SEQ_CHECKSUM_EN
        out_line[511 -: 32] = '0;
        for (int i = 0; i < NUM_PAIRS; i++) out_line[511 -: 32] = out_line[511 -: 32] ^ 32'(r_result[i]);
`endif
    end

`ifdef MUL_SEQ_CHECKSUM_EN
    generate
        if (NUM_PAIRS * DATA_LEN > 480) begin : g_csum_fit_check
            $error("mul_batch_sequencer: checksum needs NUM_PAIRS*DATA_LEN <= 480");
        end
    endgenerate
`endif

    assign out_count    = r_n;
    assign out_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mul_batch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_batch_sequencer
//  Description : Self-checking bench for mul_batch_sequencer with a pipelined
//                multiplier model and a line-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_batch_sequencer;

    localparam int DL = 32;
    localparam int PS = 2;
    localparam int NP = 8;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [511:0]   in_line;
    logic [CW-1:0]  in_count;
    logic [DL-1:0]  mul_a;
    logic [DL-1:0]  mul_b;
    logic [DL-1:0]  mul_result;
    logic           out_valid;
    logic           out_ready;
    logic [511:0]   out_line;
    logic [CW-1:0]  out_count;
    logic           out_overflow;
    logic           busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mul_batch_sequencer #(
        .DATA_LEN(DL), .PIPELINE_STAGE(PS), .NUM_PAIRS(NP), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line), .in_count(in_count),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_line(out_line),
        .out_count(out_count), .out_overflow(out_overflow), .busy(busy)
    );

    // Pipelined multiplier: product of cycle-t operands visible in cycle t+PS
    logic [DL-1:0] mpipe [PS];
    always @(posedge clk) begin
        mpipe[0] <= mul_a * mul_b;
        for (int i = 1; i < PS; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[PS-1];

    // Reference: expected result line straight from the pair layout rules
    function automatic logic [511:0] model_line(input logic [511:0] line, input int cnt);
        logic [511:0] r;
        logic [31:0]  a, b, p;
`ifdef MUL_SEQ_CHECKSUM_EN
        logic [31:0]  x;
        x = '0;
`endif
        r = '0;
        for (int i = 0; i < ((cnt > NP) ? NP : cnt); i++) begin
            a = line[64*i +: 32];
            b = line[64*i+32 +: 32];
            p = a * b;
            r[32*i +: 32] = p;
`ifdef MUL_SEQ_CHECKSUM_EN
            x = x ^ p;
`endif
        end
`ifdef MUL_SEQ_CHECKSUM_EN
        r[511:480] = x;
`endif
        return r;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int w = 0; w < 16; w++) l[32*w +: 32] = $urandom();
        return l;
    endfunction

    function automatic int exp_latency(input int cnt);
        int n;
        n = (cnt > NP) ? NP : cnt;
        return (n == 0) ? 1 : n + PS + 1;
    endfunction

    // Drive one line (DUT idle, out_ready high) and collect the returned line
    task automatic send_and_collect(input logic [511:0] line, input int cnt, output int lat,
                                    output logic [511:0] oline, output logic [CW-1:0] ocnt,
                                    output logic oovf);
        lat = -1;
        in_line  = line;
        in_count = CW'(cnt);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        oline = out_line;
        ocnt  = out_count;
        oovf  = out_overflow;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_line !== '0) begin n_fails++; $display("FAIL reset_out_line got %h want 0", out_line); end
        n_checks++; if (out_count !== '0 || out_overflow !== 1'b0) begin n_fails++; $display("FAIL reset_count_ovf got %0d/%b want 0/0", out_count, out_overflow); end
        n_checks++; if (mul_a !== '0 || mul_b !== '0) begin n_fails++; $display("FAIL reset_mul_ops got %h/%h want 0/0", mul_a, mul_b); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_pair();
        logic [511:0] l, ol; logic [CW-1:0] oc; logic ov; int lat;
        l = '0; l[31:0] = 32'd7; l[63:32] = 32'd6;
        send_and_collect(l, 1, lat, ol, oc, ov);
        n_checks++; if (lat !== 4) begin n_fails++; $display("FAIL single_latency got %0d want 4", lat); end
        n_checks++; if (ol !== {480'd0, 32'd42}) begin n_fails++; $display("FAIL single_line got %h want 42", ol); end
        n_checks++; if (oc !== 4'd1 || ov !== 1'b0) begin n_fails++; $display("FAIL single_count got %0d/%b want 1/0", oc, ov); end
    endtask

    task automatic test_full_line();
        logic [511:0] l, ol, exp; logic [CW-1:0] oc; logic ov; int lat;
        l = '0;
        for (int i = 0; i < NP; i++) begin
            l[64*i +: 32]    = 32'(i + 1);
            l[64*i+32 +: 32] = 32'(i + 2);
        end
        exp = '0;
        exp[255:0] = {32'd72, 32'd56, 32'd42, 32'd30, 32'd20, 32'd12, 32'd6, 32'd2};
`ifdef MUL_SEQ_CHECKSUM_EN
        exp[511:480] = 32'd2 ^ 32'd6 ^ 32'd12 ^ 32'd20 ^ 32'd30 ^ 32'd42 ^ 32'd56 ^ 32'd72;
`endif
        send_and_collect(l, 8, lat, ol, oc, ov);
        n_checks++; if (lat !== 11) begin n_fails++; $display("FAIL full_latency got %0d want 11", lat); end
        n_checks++; if (ol !== exp) begin n_fails++; $display("FAIL full_line got %h want %h", ol, exp); end
        n_checks++; if (oc !== 4'd8 || ov !== 1'b0) begin n_fails++; $display("FAIL full_count got %0d/%b want 8/0", oc, ov); end
    endtask

    task automatic test_zero_overflow();
        logic [511:0] l, ol; logic [CW-1:0] oc; logic ov; int lat;
        l = rand_line();
        send_and_collect(l, 0, lat, ol, oc, ov);
        n_checks++; if (lat !== 1) begin n_fails++; $display("FAIL zero_latency got %0d want 1", lat); end
        n_checks++; if (ol !== '0 || oc !== '0 || ov !== 1'b0) begin n_fails++; $display("FAIL zero_result got %h/%0d/%b want 0/0/0", ol, oc, ov); end
        l = rand_line();
        send_and_collect(l, 12, lat, ol, oc, ov);
        n_checks++; if (lat !== exp_latency(12)) begin n_fails++; $display("FAIL ovf_latency got %0d want %0d", lat, exp_latency(12)); end
        n_checks++; if (oc !== 4'd8 || ov !== 1'b1) begin n_fails++; $display("FAIL ovf_count got %0d/%b want 8/1", oc, ov); end
        n_checks++; if (ol !== model_line(l, 12)) begin n_fails++; $display("FAIL ovf_line got %h want %h", ol, model_line(l, 12)); end
    endtask

    task automatic test_backpressure();
        logic [511:0] l1, l2, held; int lat;
        l1 = rand_line(); l2 = rand_line();
        out_ready = 1'b0;
        in_line = l1; in_count = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (out_valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        held = out_line;
        n_checks++; if (lat !== exp_latency(3)) begin n_fails++; $display("FAIL bp_latency got %0d want %0d", lat, exp_latency(3)); end
        n_checks++; if (held !== model_line(l1, 3)) begin n_fails++; $display("FAIL bp_line got %h want %h", held, model_line(l1, 3)); end
        in_line = l2; in_count = 4'd5; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_line !== held || out_count !== 4'd3) begin
                n_fails++; $display("FAIL bp_hold cycle %0d got v=%b r=%b cnt=%0d line=%h want v=1 r=0 cnt=3 line=%h", c, out_valid, in_ready, out_count, out_line, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_second_accept got busy=%b r=%b want 1/0", busy, in_ready); end
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            if (out_valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== exp_latency(5) || out_line !== model_line(l2, 5)) begin n_fails++; $display("FAIL bp_second got lat=%0d line=%h want lat=%0d line=%h", lat, out_line, exp_latency(5), model_line(l2, 5)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [511:0] l, ol; logic [CW-1:0] oc; logic ov; int lat, seen;
        l = rand_line();
        in_line = l; in_count = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_line !== '0 || out_count !== '0 || out_overflow !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
            n_fails++; $display("FAIL midreset_outputs got r=%b v=%b busy=%b cnt=%0d ovf=%b a=%h line=%h want reset values", in_ready, out_valid, busy, out_count, out_overflow, mul_a, out_line);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 0) begin n_fails++; $display("FAIL midreset_no_output got %0d valid cycles want 0", seen); end
        l = '0; l[31:0] = 32'd3; l[63:32] = 32'd5;
        send_and_collect(l, 1, lat, ol, oc, ov);
        n_checks++; if (lat !== 4 || ol !== {480'd0, 32'd15} || oc !== 4'd1) begin n_fails++; $display("FAIL midreset_next got lat=%0d cnt=%0d line=%h want 4/1/15", lat, oc, ol); end
    endtask

    task automatic test_random();
        logic [511:0] l, ol; logic [CW-1:0] oc; logic ov; int lat, cnt;
        for (int t = 0; t < 12; t++) begin
            l = rand_line();
            cnt = $urandom_range(0, 15);
            send_and_collect(l, cnt, lat, ol, oc, ov);
            n_checks++;
            if (lat !== exp_latency(cnt) || ol !== model_line(l, cnt) || oc !== CW'((cnt > NP) ? NP : cnt) || ov !== (cnt > NP)) begin
                n_fails++; $display("FAIL random_%0d cnt=%0d got lat=%0d n=%0d ovf=%b line=%h want lat=%0d line=%h", t, cnt, lat, oc, ov, ol, exp_latency(cnt), model_line(l, cnt));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

`ifdef MUL_SEQ_CHECKSUM_EN
    task automatic test_checksum();
        logic [511:0] l, ol; logic [CW-1:0] oc; logic ov; int lat;
        l = '0;
        for (int i = 0; i < 3; i++) begin
            l[64*i +: 32]    = 32'(i + 1);
            l[64*i+32 +: 32] = 32'(i + 2);
        end
        send_and_collect(l, 3, lat, ol, oc, ov);
        n_checks++; if (ol[511:480] !== 32'd8) begin n_fails++; $display("FAIL checksum got %0d want 8", ol[511:480]); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_line = '0; in_count = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_single_pair();
        test_full_line();
        test_zero_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef MUL_SEQ_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_batch_sequencer.md
Name: mul_batch_sequencer

Overview:
- Sits between the AFU's cache-line read path and the pipelined `multiplier` unit; the AFU's per-line handshake control sits on both sides of it.
- Accepts one 512-bit line packed with up to NUM_PAIRS operand pairs and issues one pair per cycle into the multiplier.
- Tracks the multiplier's fixed latency with a tag shift register, collects the products into an output 512-bit line, and hands that line to the write path with valid/ready.

Parameters:
DATA_LEN, 32, operand/result width; must match the multiplier instance.
PIPELINE_STAGE, 2, multiplier latency in cycles, operands to product; must be >= 1.
NUM_PAIRS, 8, max pairs per line; 2*NUM_PAIRS*DATA_LEN <= 512 required.
CNT_W, $clog2(NUM_PAIRS+1), width of the count fields (4 at defaults).

Ports:
clk  in  1  single clock for all logic and for the attached multiplier.
reset  in  1  synchronous, active-high.
in_valid  in  1  input line valid.
in_ready  out  1  sequencer can accept a line.
in_line  in  512  operand line.
in_count  in  CNT_W  number of pairs in the line.
mul_a  out  DATA_LEN  multiplier operand a.
mul_b  out  DATA_LEN  multiplier operand b.
mul_result  in  DATA_LEN  multiplier product.
out_valid  out  1  result line valid.
out_ready  in  1  downstream accepts the result line.
out_line  out  512  packed results.
out_count  out  CNT_W  number of valid results in out_line.
out_overflow  out  1  in_count exceeded NUM_PAIRS and was clamped.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; tag register cleared.
  - Outputs: in_ready=1, out_valid=0, out_line=0, out_count=0, out_overflow=0, mul_a=0, mul_b=0, busy=0.
  - Reset mid-operation discards the captured line, all in-flight tags and partial results; no out_valid is produced for that line.
- Line layout (input): pair i has a at in_line[2i*DATA_LEN +: DATA_LEN] and b at in_line[(2i+1)*DATA_LEN +: DATA_LEN]. Bits above 2*NUM_PAIRS*DATA_LEN are ignored.
- Line layout (output): result i at out_line[i*DATA_LEN +: DATA_LEN]. All bits above the out_count results are 0.
- State IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture in_line; set N = min(in_count, NUM_PAIRS); set out_overflow = (in_count > NUM_PAIRS); clear the result buffer.
  - If N == 0, go to OUTPUT; otherwise go to ISSUE.
- State ISSUE:
  - in_ready=0.
  - In issue cycle k (k = 0..N-1), drive mul_a/mul_b with pair k and push tag {valid=1, idx=k} into the PIPELINE_STAGE-deep tag shift register.
  - After the issue of pair N-1, go to DRAIN.
- Outside ISSUE, mul_a = mul_b = 0 and a null tag is shifted in.
- Result capture:
  - The product for operands presented in cycle t is on mul_result during cycle t+PIPELINE_STAGE.
  - When the tag emerging from the shift register is valid, store mul_result at its idx.
  - Capture is independent of state.
- State DRAIN: when the tag of pair N-1 is captured, go to OUTPUT.
- Latency: with the acceptance cycle as cycle 0, issues occur in cycles 1..N and out_valid is first asserted in cycle N+PIPELINE_STAGE+1. For N == 0, out_valid is asserted in cycle 1.
- State OUTPUT:
  - out_valid=1, out_count=N; out_line and out_overflow are held stable while waiting.
  - On out_ready, go to IDLE; out_valid drops in the next cycle.
  - in_ready stays 0 until IDLE, so no new line is accepted in the cycle out_ready is seen.
  - out_ready while not in OUTPUT is ignored.
- Arithmetic: products are stored as returned, DATA_LEN bits wide (truncation is the multiplier's); the sequencer performs no arithmetic on them.
- Ordering: results are placed by tag idx, never by arrival count.

Optional Feature:
MUL_SEQ_CHECKSUM_EN:
- Defined: out_line[511 -: 32] = XOR of all N captured results, each zero-extended or truncated to 32 bits; 0 when N == 0. Requires NUM_PAIRS*DATA_LEN <= 480; violating this is an elaboration error.
- Undefined: those bits are 0, like all other unused bits.

Test Plan:
- Single pair: in_count=1, a=7, b=6, out_ready=1 → out_valid in cycle 4 (N=1, PIPELINE_STAGE=2); out_line[31:0]=42, out_count=1, rest of line 0.
- Full line: in_count=8, pairs (i+1, i+2) for i=0..7 → issues in cycles 1..8, out_valid in cycle 11; results 2,6,12,20,30,42,56,72 in slots 0..7.
- Zero/overflow: in_count=0 → out_valid in cycle 1 with out_count=0 and out_line=0. in_count=12 → N=8, out_overflow=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid → out_line stable, in_ready=0, and a second in_valid is not accepted. Raise out_ready → IDLE next cycle, second line accepted.
- Reset mid-operation: assert reset in cycle 3 of an 8-pair line → next cycle all outputs at reset values, no out_valid. The next line (a=3, b=5) returns 15.
- Checksum (MUL_SEQ_CHECKSUM_EN): results 2,6,12 → out_line[511:480] = 2^6^12 = 8.
